// File: rtl/pkg_tpu.sv
// Shared types for the issue scheduler: issue-number type, FSM state and op class
// encodings, plus the modular token-age helper used by the writeback arbiter.
package pkg_tpu;

  localparam int ISSUE_W = 8;

  typedef logic [ISSUE_W-1:0] issue_no_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  typedef enum logic {
    CLS_ADD = 1'b0,
    CLS_MLT = 1'b1
  } op_class_e;

  // Distance back from the current issue number; wraps naturally at 2^ISSUE_W.
  function automatic issue_no_t token_age(input issue_no_t cur_no, input issue_no_t tok_no);
    return cur_no - tok_no;
  endfunction

endpackage

// File: rtl/wb_age_arbiter.sv
// Combinational writeback arbiter: grants at most one finished pipe head per cycle,
// oldest token first, Mlt on a tie.
module wb_age_arbiter
  import pkg_tpu::*;
(
  input  issue_no_t i_cur_no,
  input  logic      i_done_mlt,
  input  issue_no_t i_done_no_mlt,
  input  logic      i_done_add,
  input  issue_no_t i_done_no_add,
  output logic      o_grant_mlt,
  output logic      o_grant_add
);

  issue_no_t w_age_mlt;
  issue_no_t w_age_add;
  logic      w_mlt_older;

  always_comb begin
    w_age_mlt   = token_age(i_cur_no, i_done_no_mlt);
    w_age_add   = token_age(i_cur_no, i_done_no_add);
    w_mlt_older = (w_age_mlt >= w_age_add);
  end

  assign o_grant_mlt = i_done_mlt & (~i_done_add | w_mlt_older);
  assign o_grant_add = i_done_add & ~o_grant_mlt;

endmodule

// File: rtl/pipe_issue_sched.sv
// Issue scheduler for a multiply pipe and an add pipe: credit-based issue,
// oldest-first writeback grant and a start/flush/drain control FSM.
module pipe_issue_sched
  import pkg_tpu::*;
#(
  parameter int DEPTH_MLT = 7,
  parameter int DEPTH_ADD = 5
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      I_Start,
  input  logic      I_Flush,
  input  logic      I_Req,
  input  logic      I_Class,
  output logic      O_Ack,
  output logic      O_Issue_Mlt,
  output logic      O_Issue_Add,
  output issue_no_t O_Issue_No,
  input  logic      I_Done_Mlt,
  input  logic      I_Done_Add,
  input  issue_no_t I_Done_No_Mlt,
  input  issue_no_t I_Done_No_Add,
  output logic      O_Grant_Mlt,
  output logic      O_Grant_Add,
  output issue_no_t O_Cur_No,
  output logic      O_Stall,
  output logic      O_Busy
);

  localparam int CW_MLT = $clog2(DEPTH_MLT + 1);
  localparam int CW_ADD = $clog2(DEPTH_ADD + 1);
  localparam logic [CW_MLT-1:0] FULL_MLT = CW_MLT'(DEPTH_MLT);
  localparam logic [CW_ADD-1:0] FULL_ADD = CW_ADD'(DEPTH_ADD);
  localparam int OUT_LIMIT = 2 ** (ISSUE_W - 1);

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  issue_no_t         r_cur_no;
  logic [CW_MLT-1:0] r_credit_mlt;
  logic [CW_MLT-1:0] w_credit_mlt_nxt;
  logic [CW_ADD-1:0] r_credit_add;
  logic [CW_ADD-1:0] w_credit_add_nxt;
  int                w_outstanding;
  logic              w_credit_ok;
  logic              w_ack;
  logic              w_issue_mlt;
  logic              w_issue_add;
  logic              w_arb_mlt;
  logic              w_arb_add;
  logic              w_grant_mlt;
  logic              w_grant_add;
  logic              w_done_left;

  wb_age_arbiter u_arb (
    .i_cur_no      (r_cur_no),
    .i_done_mlt    (I_Done_Mlt),
    .i_done_no_mlt (I_Done_No_Mlt),
    .i_done_add    (I_Done_Add),
    .i_done_no_add (I_Done_No_Add),
    .o_grant_mlt   (w_arb_mlt),
    .o_grant_add   (w_arb_add)
  );

  // State register: reset discards all in-flight accounting immediately.
  always_ff @(posedge clock) begin
    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cur_no     <= '0;
      r_credit_mlt <= FULL_MLT;
      r_credit_add <= FULL_ADD;
    end else begin
      r_state      <= w_state_nxt;
      r_credit_mlt <= w_credit_mlt_nxt;
      r_credit_add <= w_credit_add_nxt;
      if (w_ack) r_cur_no <= r_cur_no + 1'b1;
    end
  end

  // Output logic; every output is held low while reset is asserted.
  always_comb begin
    // NOTE: each combinationally assigned signal gets its value on every path
    // (here unconditionally) so no latch is inferred.
    w_outstanding = (DEPTH_MLT - int'(r_credit_mlt)) + (DEPTH_ADD - int'(r_credit_add));
    w_credit_ok   = (op_class_e'(I_Class) == CLS_MLT) ? (r_credit_mlt != '0)
                                                      : (r_credit_add != '0);
    w_ack         = reset & I_Req & (r_state == ST_RUN) & w_credit_ok
                  & (w_outstanding < OUT_LIMIT);
    w_issue_mlt   = w_ack & (op_class_e'(I_Class) == CLS_MLT);
    w_issue_add   = w_ack & (op_class_e'(I_Class) == CLS_ADD);
    w_grant_mlt   = reset & w_arb_mlt;
    w_grant_add   = reset & w_arb_add;
    O_Stall       = reset & I_Req & ~w_ack;
    O_Busy        = reset & ((r_state != ST_IDLE) | (w_outstanding != 0));
  end

  // Credits: issue takes one, grant returns one; a grant into a full pipe is dropped.
  always_comb begin
    w_credit_mlt_nxt = r_credit_mlt;
    if (w_grant_mlt && !w_issue_mlt) begin
      if (r_credit_mlt != FULL_MLT) w_credit_mlt_nxt = r_credit_mlt + 1'b1;
    end else if (w_issue_mlt && !w_grant_mlt) begin
      w_credit_mlt_nxt = r_credit_mlt - 1'b1;
    end

    w_credit_add_nxt = r_credit_add;
    if (w_grant_add && !w_issue_add) begin
      if (r_credit_add != FULL_ADD) w_credit_add_nxt = r_credit_add + 1'b1;
    end else if (w_issue_add && !w_grant_add) begin
      w_credit_add_nxt = r_credit_add - 1'b1;
    end
  end

  // A completion granted this cycle counts as consumed when deciding to leave DRAIN.
  assign w_done_left = (I_Done_Mlt & ~w_grant_mlt) | (I_Done_Add & ~w_grant_add);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (I_Start && !I_Flush) w_state_nxt = ST_RUN;
      ST_RUN:   if (I_Flush) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if ((w_credit_mlt_nxt == FULL_MLT) && (w_credit_add_nxt == FULL_ADD)
                    && !w_done_left) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign O_Ack       = w_ack;
  assign O_Issue_Mlt = w_issue_mlt;
  assign O_Issue_Add = w_issue_add;
  assign O_Issue_No  = r_cur_no;
  assign O_Grant_Mlt = w_grant_mlt;
  assign O_Grant_Add = w_grant_add;
  assign O_Cur_No    = r_cur_no;

endmodule

// File: tb/tb_pipe_issue_sched.sv
// Self-checking bench for pipe_issue_sched: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model with pipe queues.
module tb_pipe_issue_sched;
  import pkg_tpu::*;

  localparam int DM = 7;
  localparam int DA = 5;
  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_DRAIN = 2;

  logic      clock = 1'b0;
  logic      reset;
  logic      I_Start, I_Flush, I_Req, I_Class;
  logic      O_Ack, O_Issue_Mlt, O_Issue_Add;
  issue_no_t O_Issue_No;
  logic      I_Done_Mlt, I_Done_Add;
  issue_no_t I_Done_No_Mlt, I_Done_No_Add;
  logic      O_Grant_Mlt, O_Grant_Add;
  issue_no_t O_Cur_No;
  logic      O_Stall, O_Busy;

  always #5 clock = ~clock;

  pipe_issue_sched #(.DEPTH_MLT(DM), .DEPTH_ADD(DA)) dut (
    .clock         (clock),
    .reset         (reset),
    .I_Start       (I_Start),
    .I_Flush       (I_Flush),
    .I_Req         (I_Req),
    .I_Class       (I_Class),
    .O_Ack         (O_Ack),
    .O_Issue_Mlt   (O_Issue_Mlt),
    .O_Issue_Add   (O_Issue_Add),
    .O_Issue_No    (O_Issue_No),
    .I_Done_Mlt    (I_Done_Mlt),
    .I_Done_Add    (I_Done_Add),
    .I_Done_No_Mlt (I_Done_No_Mlt),
    .I_Done_No_Add (I_Done_No_Add),
    .O_Grant_Mlt   (O_Grant_Mlt),
    .O_Grant_Add   (O_Grant_Add),
    .O_Cur_No      (O_Cur_No),
    .O_Stall       (O_Stall),
    .O_Busy        (O_Busy)
  );

  int checks = 0;
  int errors = 0;
  int chk_en = 0;
  int cyc = 0;

  // Behavioural model state
  int m_state = M_IDLE;
  int m_cur = 0;
  int m_cm = DM;
  int m_ca = DA;

  // Applied stimulus and model expectations for the current cycle
  int s_rst, s_st, s_fl, s_rq, s_cl, s_dm, s_nm, s_da, s_na;
  int e_ack, e_im, e_ia, e_gm, e_ga, e_stall, e_busy;

  // Bench-side pipes: token numbers and the cycle each finishes
  int q_no_m[$];
  int q_rdy_m[$];
  int q_no_a[$];
  int q_rdy_a[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_expect();
    int outst, age_m, age_a;
    bit cred_ok;
    outst = (DM - m_cm) + (DA - m_ca);
    e_ack = 0; e_im = 0; e_ia = 0; e_gm = 0; e_ga = 0; e_stall = 0; e_busy = 0;
    if (s_rst != 0) begin
      cred_ok = (s_cl != 0) ? (m_cm > 0) : (m_ca > 0);
      e_ack   = (s_rq != 0 && m_state == M_RUN && cred_ok && outst < 128) ? 1 : 0;
      e_im    = (e_ack != 0 && s_cl != 0) ? 1 : 0;
      e_ia    = (e_ack != 0 && s_cl == 0) ? 1 : 0;
      age_m   = (m_cur - s_nm) & 255;
      age_a   = (m_cur - s_na) & 255;
      e_gm    = (s_dm != 0 && (s_da == 0 || age_m >= age_a)) ? 1 : 0;
      e_ga    = (s_da != 0 && e_gm == 0) ? 1 : 0;
      e_stall = (s_rq != 0 && e_ack == 0) ? 1 : 0;
      e_busy  = (m_state != M_IDLE || outst != 0) ? 1 : 0;
    end
  endtask

  // Apply one cycle of inputs (called just after a falling edge) and compare.
  task automatic drive(input int rst, input int st, input int fl, input int rq, input int cl,
                       input int dm, input int nm, input int da, input int na);
    s_rst = rst; s_st = st; s_fl = fl; s_rq = rq; s_cl = cl;
    s_dm = dm; s_nm = nm & 255; s_da = da; s_na = na & 255;
    reset         = (rst != 0);
    I_Start       = (st != 0);
    I_Flush       = (fl != 0);
    I_Req         = (rq != 0);
    I_Class       = (cl != 0);
    I_Done_Mlt    = (dm != 0);
    I_Done_No_Mlt = issue_no_t'(s_nm);
    I_Done_Add    = (da != 0);
    I_Done_No_Add = issue_no_t'(s_na);
    #1;
    model_expect();
    if (chk_en != 0) begin
      check("ack", int'(O_Ack), e_ack);
      check("issue_mlt", int'(O_Issue_Mlt), e_im);
      check("issue_add", int'(O_Issue_Add), e_ia);
      if (e_ack != 0) check("issue_no", int'(O_Issue_No), m_cur);
      check("grant_mlt", int'(O_Grant_Mlt), e_gm);
      check("grant_add", int'(O_Grant_Add), e_ga);
      check("stall", int'(O_Stall), e_stall);
      check("busy", int'(O_Busy), e_busy);
      check("cur_no", int'(O_Cur_No), m_cur);
    end
  endtask

  // Advance one clock and update the model with what that edge commits.
  task automatic tick();
    @(posedge clock);
    if (s_rst == 0) begin
      m_state = M_IDLE; m_cur = 0; m_cm = DM; m_ca = DA;
    end else begin
      m_cur = (m_cur + e_ack) & 255;
      m_cm  = m_cm + e_gm - e_im;
      if (m_cm > DM) m_cm = DM;
      m_ca  = m_ca + e_ga - e_ia;
      if (m_ca > DA) m_ca = DA;
      case (m_state)
        M_IDLE:  if (s_st != 0 && s_fl == 0) m_state = M_RUN;
        M_RUN:   if (s_fl != 0) m_state = M_DRAIN;
        default: if (m_cm == DM && m_ca == DA && !(s_dm != 0 && e_gm == 0)
                     && !(s_da != 0 && e_ga == 0)) m_state = M_IDLE;
      endcase
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    reset = 1'b0; I_Start = 1'b0; I_Flush = 1'b0; I_Req = 1'b0; I_Class = 1'b0;
    I_Done_Mlt = 1'b0; I_Done_Add = 1'b0; I_Done_No_Mlt = '0; I_Done_No_Add = '0;
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_en = 1;

    // Reset state, then 7 Mlt issues fill the pipe; the 8th stalls.
    do_reset();
    check("rst_busy", int'(O_Busy), 0);
    check("rst_cur_no", int'(O_Cur_No), 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
      check("fill_ack", int'(O_Ack), 1);
      check("fill_issue_no", int'(O_Issue_No), i);
      check("fill_issue_mlt", int'(O_Issue_Mlt), 1);
      tick();
    end
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
    check("full_stall", int'(O_Stall), 1);
    check("full_ack", int'(O_Ack), 0);
    tick();

    // Grant with zero credit: refused now, accepted next cycle.
    drive(1, 0, 0, 1, 1, 1, 0, 0, 0);
    check("zero_cred_ack", int'(O_Ack), 0);
    check("zero_cred_grant", int'(O_Grant_Mlt), 1);
    tick();
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
    check("cred_back_ack", int'(O_Ack), 1);
    check("cred_back_issue_no", int'(O_Issue_No), 7);
    tick();

    // Age arbitration at cur_no=10: Mlt(4) older than Add(7).
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 1, (i < 5) ? 1 : 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 1, 4, 1, 7);
    check("age_cur_no", int'(O_Cur_No), 10);
    check("age_grant_mlt", int'(O_Grant_Mlt), 1);
    check("age_grant_add", int'(O_Grant_Add), 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 7);
    check("age_next_grant_add", int'(O_Grant_Add), 1);
    check("age_next_grant_mlt", int'(O_Grant_Mlt), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 1, i, 0, 0);
      tick();
    end

    // Reset in RUN with 4 tokens outstanding, request and completions held high.
    drive(0, 0, 0, 1, 1, 1, 3, 1, 5);
    tick();
    drive(0, 0, 0, 1, 1, 1, 3, 1, 5);
    check("midrst_ack", int'(O_Ack), 0);
    check("midrst_stall", int'(O_Stall), 0);
    check("midrst_grant_mlt", int'(O_Grant_Mlt), 0);
    check("midrst_grant_add", int'(O_Grant_Add), 0);
    check("midrst_issue_mlt", int'(O_Issue_Mlt), 0);
    check("midrst_issue_add", int'(O_Issue_Add), 0);
    check("midrst_busy", int'(O_Busy), 0);
    check("midrst_cur_no", int'(O_Cur_No), 0);
    check("midrst_issue_no", int'(O_Issue_No), 0);
    tick();
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
    check("postrst_busy", int'(O_Busy), 0);
    check("postrst_stall", int'(O_Stall), 1);
    tick();

    // Flush with 3 in flight: no acks, busy until the 3rd grant, then IDLE.
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, (i < 2) ? 1 : 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
    check("flush_busy", int'(O_Busy), 1);
    tick();
    drive(1, 0, 0, 1, 1, 1, 0, 1, 2);
    check("drain1_ack", int'(O_Ack), 0);
    check("drain1_grant_mlt", int'(O_Grant_Mlt), 1);
    check("drain1_busy", int'(O_Busy), 1);
    tick();
    drive(1, 0, 0, 1, 0, 1, 1, 1, 2);
    check("drain2_grant_mlt", int'(O_Grant_Mlt), 1);
    check("drain2_busy", int'(O_Busy), 1);
    tick();
    drive(1, 0, 0, 1, 0, 0, 0, 1, 2);
    check("drain3_grant_add", int'(O_Grant_Add), 1);
    check("drain3_ack", int'(O_Ack), 0);
    check("drain3_busy", int'(O_Busy), 1);
    tick();
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
    check("drained_busy", int'(O_Busy), 0);
    check("drained_ack", int'(O_Ack), 0);
    tick();

    // Issue-number wrap: cur_no=2, Mlt done_no=250 (age 8) beats Add done_no=1 (age 1).
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 257; i++) begin
      drive(1, 0, 0, 1, 0, 0, 0, 1, i);
      tick();
    end
    drive(1, 0, 0, 0, 0, 1, 250, 1, 1);
    check("wrap_cur_no", int'(O_Cur_No), 2);
    check("wrap_grant_mlt", int'(O_Grant_Mlt), 1);
    check("wrap_grant_add", int'(O_Grant_Add), 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
    check("wrap_next_grant_add", int'(O_Grant_Add), 1);
    tick();

    // Randomized traffic against the model; the bench acts as both pipes.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int rst, dm, nm, da, na;
      rst = ($urandom_range(0, 799) == 0) ? 0 : 1;
      dm = (q_no_m.size() > 0 && q_rdy_m[0] <= cyc) ? 1 : 0;
      nm = (dm != 0) ? q_no_m[0] : int'($urandom_range(0, 255));
      da = (q_no_a.size() > 0 && q_rdy_a[0] <= cyc) ? 1 : 0;
      na = (da != 0) ? q_no_a[0] : int'($urandom_range(0, 255));
      drive(rst, ($urandom_range(0, 7) == 0) ? 1 : 0, ($urandom_range(0, 79) == 0) ? 1 : 0,
            ($urandom_range(0, 9) < 7) ? 1 : 0, int'($urandom_range(0, 1)), dm, nm, da, na);
      if (rst == 0) begin
        q_no_m.delete(); q_rdy_m.delete(); q_no_a.delete(); q_rdy_a.delete();
      end else begin
        if (e_gm != 0) begin void'(q_no_m.pop_front()); void'(q_rdy_m.pop_front()); end
        if (e_ga != 0) begin void'(q_no_a.pop_front()); void'(q_rdy_a.pop_front()); end
        if (e_im != 0) begin q_no_m.push_back(m_cur); q_rdy_m.push_back(cyc + int'($urandom_range(1, 12))); end
        if (e_ia != 0) begin q_no_a.push_back(m_cur); q_rdy_a.push_back(cyc + int'($urandom_range(1, 12))); end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
